// File: rtl/sms_sram_bank_ctrl.sv
// SRAM bank controller: maps SMS AHB bank accesses onto a single-port synchronous macro,
// with idle-driven light-sleep, stalled wake-up and replay of the access that caused the wake.
module sms_sram_bank_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int WAKE_CYC = 2,
   parameter int IDLE_W   = 8
) (
   input  logic              i_sys_hclk,
   input  logic              i_sys_rst_b,
   input  logic              ram_sel,
   input  logic              ram_write,
   input  logic [2:0]        ram_size,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic [31:0]       ram_wdata,
   input  logic              ram_idle,
   input  logic              sleep_en,
   input  logic [IDLE_W-1:0] idle_thresh,
   output logic [31:0]       ram_rdata,
   output logic              ram_stall,
   output logic              ram_err,
   output logic              mem_cen,
   output logic [3:0]        mem_wen,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout,
   output logic              mem_ls
);

   // Counter holds the number of WAKE cycles still to pass before the access cycle.
   localparam int              WK_W    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
   localparam logic [WK_W-1:0] WK_LOAD = WK_W'(WAKE_CYC - 1);

   typedef enum logic [1:0] {ST_ACTIVE = 2'd0, ST_SLEEP = 2'd1, ST_WAKE = 2'd2} state_t;

   function automatic logic f_legal(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         3'd0:    return 1'b1;
         3'd1:    return ~lo[0];
         3'd2:    return (lo == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] f_wen(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         3'd0:    return ~(4'b0001 << lo);
         3'd1:    return lo[1] ? 4'b0011 : 4'b1100;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [IDLE_W-1:0] f_sat_inc(input logic [IDLE_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t              r_state, w_next;
   logic                r_pend, r_pend_write;
   logic [2:0]          r_pend_size;
   logic [ADDR_W-1:0]   r_pend_addr;
   logic [31:0]         r_pend_wdata;
   logic [WK_W-1:0]     r_wake_cnt;
   logic [IDLE_W-1:0]   r_idle_cnt;
   logic                r_rd_vld_p1, r_err_p1, r_ls;
   logic [31:0]         r_rdata_hold;

   logic                w_acc_sel, w_acc_write;
   logic [2:0]          w_acc_size;
   logic [ADDR_W-1:0]   w_acc_addr;
   logic [31:0]         w_acc_wdata;
   logic                w_latch, w_clr_pend, w_load_wake, w_legal, w_issue, w_sleep_go;

   assign w_sleep_go = sleep_en & (idle_thresh != '0) & (r_idle_cnt >= idle_thresh) & ~ram_sel;

   always_comb begin
      w_next      = r_state;
      w_acc_sel   = 1'b0;
      w_acc_write = ram_write;
      w_acc_size  = ram_size;
      w_acc_addr  = ram_addr;
      w_acc_wdata = ram_wdata;
      ram_stall   = 1'b0;
      w_latch     = 1'b0;
      w_clr_pend  = 1'b0;
      w_load_wake = 1'b0;
      case (r_state)
         ST_ACTIVE: begin
            w_acc_sel = ram_sel;
            if (w_sleep_go) w_next = ST_SLEEP;
         end
         ST_SLEEP: begin
            if (ram_sel) begin
               w_latch     = 1'b1;
               ram_stall   = 1'b1;
               w_load_wake = 1'b1;
               w_next      = ST_WAKE;
            end else if (!sleep_en) begin
               w_load_wake = 1'b1;
               w_next      = ST_WAKE;
            end
         end
         ST_WAKE: begin
            if (r_wake_cnt == '0) begin
               w_next     = ST_ACTIVE;
               w_clr_pend = 1'b1;
               // Access cycle: replay the held request, or take a fresh one directly.
               if (r_pend) begin
                  w_acc_sel   = 1'b1;
                  w_acc_write = r_pend_write;
                  w_acc_size  = r_pend_size;
                  w_acc_addr  = r_pend_addr;
                  w_acc_wdata = r_pend_wdata;
                  ram_stall   = 1'b1;
               end else begin
                  w_acc_sel = ram_sel;
               end
            end else if (r_pend) begin
               ram_stall = 1'b1;
            end else if (ram_sel) begin
               w_latch   = 1'b1;
               ram_stall = 1'b1;
            end
         end
         default: w_next = ST_ACTIVE;
      endcase
   end

   assign w_legal   = f_legal(w_acc_size, w_acc_addr[1:0]);
   assign w_issue   = w_acc_sel & w_legal;
   assign mem_cen   = ~w_issue;
   assign mem_wen   = (w_issue & w_acc_write) ? f_wen(w_acc_size, w_acc_addr[1:0]) : 4'hF;
   assign mem_addr  = w_acc_addr[ADDR_W-1:2];
   assign mem_din   = w_acc_wdata;
   assign mem_ls    = r_ls;
   assign ram_err   = r_err_p1;
   assign ram_rdata = r_rd_vld_p1 ? mem_dout : (r_err_p1 ? 32'h0 : r_rdata_hold);

   // Stage p1: read-valid / error flags and control state for the following cycle.
   always_ff @(posedge i_sys_hclk or negedge i_sys_rst_b) begin
      if (!i_sys_rst_b) begin
         r_state      <= ST_ACTIVE;
         r_pend       <= 1'b0;
         r_wake_cnt   <= '0;
         r_idle_cnt   <= '0;
         r_rd_vld_p1  <= 1'b0;
         r_err_p1     <= 1'b0;
         r_ls         <= 1'b0;
         r_rdata_hold <= '0;
      end else begin
         r_state     <= w_next;
         r_ls        <= (w_next == ST_SLEEP);
         r_rd_vld_p1 <= w_issue & ~w_acc_write;
         r_err_p1    <= w_acc_sel & ~w_legal;
         if (r_rd_vld_p1) r_rdata_hold <= mem_dout;
         if (w_clr_pend)   r_pend <= 1'b0;
         else if (w_latch) r_pend <= 1'b1;
         if (w_load_wake)
            r_wake_cnt <= WK_LOAD;
         else if (r_state == ST_WAKE && r_wake_cnt != '0)
            r_wake_cnt <= r_wake_cnt - 1'b1;
         if (r_state != ST_ACTIVE || ram_sel || !ram_idle)
            r_idle_cnt <= '0;
         else
            r_idle_cnt <= f_sat_inc(r_idle_cnt);
      end
   end

   always_ff @(posedge i_sys_hclk) begin
      if (w_latch) begin
         r_pend_write <= ram_write;
         r_pend_size  <= ram_size;
         r_pend_addr  <= ram_addr;
         r_pend_wdata <= ram_wdata;
      end
   end

endmodule

// File: tb/tb_sms_sram_bank_ctrl.sv
// Bench for sms_sram_bank_ctrl: directed vectors, a macro model, and a cycle reference model
// built from byte-lane arithmetic and a byte-addressed reference memory.
module tb_sms_sram_bank_ctrl;
   localparam int ADDR_W = 16, WAKE_CYC = 2, IDLE_W = 8;
   localparam int MD_RUN = 0, MD_SLEEP = 1, MD_WAKE = 2;

   logic        clk = 1'b0, rst_b;
   logic        ram_sel, ram_write, ram_idle, sleep_en;
   logic [2:0]  ram_size;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata, mem_din, mem_dout;
   logic [7:0]  idle_thresh;
   logic        ram_stall, ram_err, mem_cen, mem_ls;
   logic [3:0]  mem_wen;
   logic [13:0] mem_addr;

   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   sms_sram_bank_ctrl #(.ADDR_W(ADDR_W), .WAKE_CYC(WAKE_CYC), .IDLE_W(IDLE_W)) dut (
      .i_sys_hclk(clk), .i_sys_rst_b(rst_b),
      .ram_sel(ram_sel), .ram_write(ram_write), .ram_size(ram_size), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_idle(ram_idle), .sleep_en(sleep_en), .idle_thresh(idle_thresh),
      .ram_rdata(ram_rdata), .ram_stall(ram_stall), .ram_err(ram_err),
      .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_ls(mem_ls));

   // Macro model: 1-cycle read latency, byte write enables active-low.
   logic [31:0] macro_mem [0:16383];
   logic [31:0] macro_dout = 32'h0;
   bit          wrote_40 = 1'b0;
   assign mem_dout = macro_dout;
   always @(posedge clk) begin
      if (!mem_cen) begin
         if (mem_wen != 4'hF) begin
            for (int i = 0; i < 4; i++)
               if (!mem_wen[i]) macro_mem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
            if (mem_addr == 14'h0010) wrote_40 <= 1'b1;
         end else begin
            macro_dout <= macro_mem[mem_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model
   typedef struct packed {
      logic        v;
      logic        w;
      logic [2:0]  sz;
      logic [15:0] a;
      logic [31:0] d;
   } acc_t;

   logic [7:0]  ref_mem [0:65535];
   int          m_mode = MD_RUN, m_wake_n = 0, m_idle = 0;
   acc_t        m_pend = '0;
   logic        m_ls = 1'b0, m_err = 1'b0, m_rvld = 1'b0;
   logic [31:0] m_rword = 32'h0, m_hold = 32'h0;

   always @(negedge clk) begin : model
      acc_t        cur, acc;
      logic        stall, legal, issue;
      int          nmode, nb;
      logic [3:0]  lanes, ewen;
      logic [31:0] erd;
      if (!rst_b) begin
         m_mode = MD_RUN; m_pend = '0; m_idle = 0; m_wake_n = 0;
         m_ls = 1'b0; m_err = 1'b0; m_rvld = 1'b0; m_hold = 32'h0;
         chk("rst_mem_cen", mem_cen, 32'h1);
         chk("rst_mem_wen", mem_wen, 32'hF);
         chk("rst_mem_ls", mem_ls, 32'h0);
         chk("rst_ram_stall", ram_stall, 32'h0);
         chk("rst_ram_err", ram_err, 32'h0);
         chk("rst_ram_rdata", ram_rdata, 32'h0);
      end else begin
         erd = m_rvld ? m_rword : (m_err ? 32'h0 : m_hold);
         chk("ram_rdata", ram_rdata, erd);
         chk("ram_err", ram_err, {31'h0, m_err});
         chk("mem_ls", mem_ls, {31'h0, m_ls});
         cur   = '{ram_sel, ram_write, ram_size, ram_addr, ram_wdata};
         acc   = '0;
         stall = 1'b0;
         nmode = m_mode;
         case (m_mode)
            MD_RUN: begin
               acc = cur;
               if (sleep_en && idle_thresh != 0 && m_idle >= int'(idle_thresh) && !ram_sel)
                  nmode = MD_SLEEP;
            end
            MD_SLEEP: begin
               if (ram_sel) begin
                  m_pend = cur; stall = 1'b1; nmode = MD_WAKE; m_wake_n = 1;
               end else if (!sleep_en) begin
                  nmode = MD_WAKE; m_wake_n = 1;
               end
            end
            default: begin
               if (m_wake_n >= WAKE_CYC) begin
                  nmode = MD_RUN;
                  if (m_pend.v) begin
                     acc = m_pend; stall = 1'b1;
                  end else begin
                     acc = cur;
                  end
                  m_pend.v = 1'b0;
               end else begin
                  if (m_pend.v) stall = 1'b1;
                  else if (ram_sel) begin
                     m_pend = cur; stall = 1'b1;
                  end
                  m_wake_n++;
               end
            end
         endcase
         if (acc.sz <= 3'd2) begin
            nb    = 1 << acc.sz;
            legal = (int'(acc.a) % nb) == 0;
            lanes = 4'(((1 << nb) - 1) << acc.a[1:0]);
         end else begin
            legal = 1'b0;
            lanes = 4'h0;
         end
         issue = acc.v && legal;
         ewen  = (issue && acc.w) ? ~lanes : 4'hF;
         chk("mem_cen", mem_cen, {31'h0, !issue});
         chk("ram_stall", ram_stall, {31'h0, stall});
         chk("mem_wen", mem_wen, {28'h0, ewen});
         if (issue) chk("mem_addr", mem_addr, {18'h0, acc.a[15:2]});
         if (issue && acc.w) chk("mem_din", mem_din, acc.d);
         if (m_rvld) m_hold = m_rword;
         m_rvld = issue && !acc.w;
         if (m_rvld)
            m_rword = {ref_mem[{acc.a[15:2], 2'd3}], ref_mem[{acc.a[15:2], 2'd2}],
                       ref_mem[{acc.a[15:2], 2'd1}], ref_mem[{acc.a[15:2], 2'd0}]};
         if (issue && acc.w)
            for (int i = 0; i < 4; i++)
               if (lanes[i]) ref_mem[{acc.a[15:2], 2'(i)}] = acc.d[8*i +: 8];
         m_err = acc.v && !legal;
         if (m_mode != MD_RUN || ram_sel || !ram_idle) m_idle = 0;
         else if (m_idle < (1 << IDLE_W) - 1) m_idle++;
         m_mode = nmode;
         m_ls   = (nmode == MD_SLEEP);
      end
   end

   task automatic step(input logic s, input logic w, input logic [2:0] sz,
                       input logic [15:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      ram_sel = s; ram_write = w; ram_size = sz; ram_addr = a; ram_wdata = d;
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
   endtask

   task automatic wait_sleep(input string name);
      int k = 0;
      while (!mem_ls && k < 20) begin
         idle_step();
         @(negedge clk);
         k++;
      end
      chk(name, mem_ls, 32'h1);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) macro_mem[i] = 32'h0;
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h0;
      rst_b = 1'b0; ram_sel = 1'b0; ram_write = 1'b0; ram_size = 3'd0; ram_addr = 16'h0;
      ram_wdata = 32'h0; ram_idle = 1'b1; sleep_en = 1'b0; idle_thresh = 8'd0;
      @(negedge clk);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_din", mem_din, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b1;

      step(1'b1, 1'b1, 3'd2, 16'h0020, 32'hDEAD_BEEF);
      // Word write then read
      step(1'b1, 1'b1, 3'd2, 16'h0010, 32'hA5A5_0F0F);
      @(negedge clk);
      chk("t1_wen", mem_wen, 32'h0);
      chk("t1_addr", mem_addr, 32'h004);
      chk("t1_cen", mem_cen, 32'h0);
      step(1'b1, 1'b0, 3'd2, 16'h0010, 32'h0);
      @(negedge clk);
      chk("t1_rd_wen", mem_wen, 32'hF);
      idle_step();
      @(negedge clk);
      chk("t1_rdata", ram_rdata, 32'hA5A5_0F0F);

      // Byte and halfword lanes
      step(1'b1, 1'b1, 3'd0, 16'h0013, 32'h7700_0000);
      @(negedge clk);
      chk("t2_byte_wen", mem_wen, 32'h7);
      chk("t2_byte_stall", ram_stall, 32'h0);
      step(1'b1, 1'b1, 3'd1, 16'h0012, 32'h1234_0000);
      @(negedge clk);
      chk("t2_half_wen", mem_wen, 32'h3);
      chk("t2_half_stall", ram_stall, 32'h0);
      step(1'b1, 1'b0, 3'd2, 16'h0010, 32'h0);
      idle_step();
      @(negedge clk);
      chk("t2_rdata", ram_rdata, 32'h1234_0F0F);

      // Illegal accesses
      step(1'b1, 1'b0, 3'd1, 16'h0001, 32'h0);
      @(negedge clk);
      chk("t5_half_cen", mem_cen, 32'h1);
      idle_step();
      @(negedge clk);
      chk("t5_half_err", ram_err, 32'h1);
      chk("t5_half_rdata", ram_rdata, 32'h0);
      idle_step();
      @(negedge clk);
      chk("t5_err_drop", ram_err, 32'h0);
      chk("t5_hold_back", ram_rdata, 32'h1234_0F0F);
      step(1'b1, 1'b1, 3'd3, 16'h0004, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("t5_sz3_cen", mem_cen, 32'h1);
      chk("t5_sz3_wen", mem_wen, 32'hF);
      idle_step();
      @(negedge clk);
      chk("t5_sz3_err", ram_err, 32'h1);

      // Idle into light-sleep: ls rises on the 5th edge after the access edge
      step(1'b1, 1'b1, 3'd2, 16'h0030, 32'h1111_2222);
      sleep_en = 1'b1; idle_thresh = 8'd4;
      for (int k = 1; k <= 6; k++) begin
         idle_step();
         @(negedge clk);
         chk($sformatf("t3_ls_c%0d", k), mem_ls, (k == 6) ? 32'h1 : 32'h0);
         chk($sformatf("t3_cen_c%0d", k), mem_cen, 32'h1);
      end

      // Read in sleep: 3 stall cycles, access on the 3rd
      idle_step();
      idle_step();
      step(1'b1, 1'b0, 3'd2, 16'h0020, 32'h0);
      @(negedge clk);
      chk("t4_a_stall", ram_stall, 32'h1);
      chk("t4_a_cen", mem_cen, 32'h1);
      idle_step();
      @(negedge clk);
      chk("t4_b_stall", ram_stall, 32'h1);
      chk("t4_b_cen", mem_cen, 32'h1);
      chk("t4_b_ls", mem_ls, 32'h0);
      idle_step();
      @(negedge clk);
      chk("t4_c_stall", ram_stall, 32'h1);
      chk("t4_c_cen", mem_cen, 32'h0);
      chk("t4_c_addr", mem_addr, 32'h008);
      idle_step();
      @(negedge clk);
      chk("t4_d_stall", ram_stall, 32'h0);
      chk("t4_d_rdata", ram_rdata, 32'hDEAD_BEEF);

      // Reset during WAKE with a pending write
      wait_sleep("t6_sleep_reached");
      step(1'b1, 1'b1, 3'd2, 16'h0040, 32'hCAFE_F00D);
      idle_step();
      #2;
      rst_b = 1'b0; sleep_en = 1'b0;
      @(negedge clk);
      chk("t6_cen", mem_cen, 32'h1);
      chk("t6_wen", mem_wen, 32'hF);
      chk("t6_addr", mem_addr, 32'h0);
      chk("t6_din", mem_din, 32'h0);
      chk("t6_stall", ram_stall, 32'h0);
      chk("t6_ls", mem_ls, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b1;
      chk("t6_no_write", {31'h0, wrote_40}, 32'h0);
      step(1'b1, 1'b0, 3'd2, 16'h0040, 32'h0);
      idle_step();
      @(negedge clk);
      chk("t6_rdata_0x40", ram_rdata, 32'h0);

      // Sleep exit via sleep_en, request arriving during WAKE
      sleep_en = 1'b1; idle_thresh = 8'd2;
      wait_sleep("t7_sleep_reached");
      idle_step();
      sleep_en = 1'b0;
      @(negedge clk);
      chk("t7_a_stall", ram_stall, 32'h0);
      step(1'b1, 1'b0, 3'd2, 16'h0010, 32'h0);
      @(negedge clk);
      chk("t7_b_stall", ram_stall, 32'h1);
      chk("t7_b_cen", mem_cen, 32'h1);
      idle_step();
      @(negedge clk);
      chk("t7_c_cen", mem_cen, 32'h0);
      chk("t7_c_stall", ram_stall, 32'h1);
      idle_step();
      @(negedge clk);
      chk("t7_d_stall", ram_stall, 32'h0);
      chk("t7_d_rdata", ram_rdata, 32'h1234_0F0F);

      // Idle counter saturates rather than wrapping
      idle_thresh = 8'd255;
      repeat (300) idle_step();
      idle_step();
      sleep_en = 1'b1;
      @(negedge clk);
      chk("t8_ls_before", mem_ls, 32'h0);
      idle_step();
      sleep_en = 1'b0;
      @(negedge clk);
      chk("t8_ls_sat", mem_ls, 32'h1);
      repeat (5) idle_step();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
